if_fetch_unit: RTL

Instruction-fetch stage of the 5-stage RV32 pipeline: owns the program counter, drives the instruction-memory address, and makes a next-PC prediction with a direct-mapped branch target buffer (BTB) of 2-bit saturating counters. It feeds the IF/ID pipeline register with PC+4, the predicted branch target and the prediction bit. It also accepts branch-resolution and redirect information back from EX.

---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_btb_predictor.sv | 71 +++++++
 rtl/if_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared RV32 constants, counter encodings and PC helpers
// for the fetch stage and its branch target buffer.
package RV32_Constants;

   localparam logic [31:0] ZERO_VECTOR_32      = 32'h0000_0000;
   localparam logic [31:0] INVALID_INSTRUCTION = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   function automatic logic [31:0] align_pc(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   function automatic ctr_e ctr_inc(input ctr_e c);
      return (c == STRONG_T) ? STRONG_T : ctr_e'(c + 2'd1);
   endfunction

   function automatic ctr_e ctr_dec(input ctr_e c);
      return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
   endfunction

endpackage

// File: rtl/if_fetch_unit_btb_predictor.sv
// Direct-mapped BTB with 2-bit counters: zero-latency lookup,
// training and allocation from EX branch resolution.
module btb_predictor
   import RV32_Constants::*;
#(
   parameter int IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_lookup_pc,
   output logic        o_pred,
   output logic [31:0] o_target,
   input  logic        i_upd_valid,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_pc,
   input  logic [31:0] i_upd_target
);

   localparam int N  = 1 << IDX_BITS;
   localparam int TW = 30 - IDX_BITS;

   logic          r_valid  [N];
   logic [TW-1:0] r_tag    [N];
   logic [31:0]   r_target [N];
   ctr_e          r_ctr    [N];

   logic [IDX_BITS-1:0] w_l_idx, w_u_idx;
   logic [TW-1:0]       w_l_tag, w_u_tag;
   logic                w_l_hit, w_u_hit;
   logic                w_unused;

   assign w_l_idx = i_lookup_pc[IDX_BITS+1:2];
   assign w_l_tag = i_lookup_pc[31:IDX_BITS+2];
   assign w_u_idx = i_upd_pc[IDX_BITS+1:2];
   assign w_u_tag = i_upd_pc[31:IDX_BITS+2];
   assign w_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

   assign w_l_hit = r_valid[w_l_idx] && (r_tag[w_l_idx] == w_l_tag);
   assign w_u_hit = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

   assign o_pred   = w_l_hit && ((r_ctr[w_l_idx] == WEAK_T) ||
                                 (r_ctr[w_l_idx] == STRONG_T));
   assign o_target = w_l_hit ? r_target[w_l_idx] : ZERO_VECTOR_32;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= ZERO_VECTOR_32;
            r_ctr[i]    <= STRONG_NT;
         end
      end else if (i_upd_valid) begin
         if (w_u_hit) begin
            if (i_upd_taken) begin
               r_ctr[w_u_idx]    <= ctr_inc(r_ctr[w_u_idx]);
               r_target[w_u_idx] <= i_upd_target;
            end else begin
               r_ctr[w_u_idx] <= ctr_dec(r_ctr[w_u_idx]);
            end
         end else if (i_upd_taken) begin
            // Miss on a taken branch replaces whatever aliased here.
            r_valid[w_u_idx]  <= 1'b1;
            r_tag[w_u_idx]    <= w_u_tag;
            r_target[w_u_idx] <= i_upd_target;
            r_ctr[w_u_idx]    <= WEAK_T;
         end
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 instruction-fetch stage: PC register, next-PC select, flush.
// Optional BTB prediction is built only when FETCH_BTB_EN is defined.
module if_fetch_unit
   import RV32_Constants::*;
#(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter int          BTB_IDX_BITS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PC_Write,
   input  logic        EX_Branch_Valid,
   input  logic        EX_Branch_Taken,
   input  logic [31:0] EX_Branch_PC,
   input  logic [31:0] EX_Branch_Target,
   input  logic        EX_Mispredict,
   input  logic [31:0] EX_Redirect_PC,
   output logic [31:0] Imem_Addr,
   output logic [31:0] IF_PC_New,
   output logic        IF_Prediction,
   output logic [31:0] IF_Branch_Target,
   output logic        IF_ID_Flush
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_next;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_btb_target;
   logic        w_pred;

   assign w_pc_plus4 = r_pc + 32'd4;

`ifdef FETCH_BTB_EN
   btb_predictor #(
      .IDX_BITS(BTB_IDX_BITS)
   ) u_btb (
      .clk         (clk),
      .reset       (reset),
      .i_lookup_pc (r_pc),
      .o_pred      (w_pred),
      .o_target    (w_btb_target),
      .i_upd_valid (EX_Branch_Valid),
      .i_upd_taken (EX_Branch_Taken),
      .i_upd_pc    (EX_Branch_PC),
      .i_upd_target(EX_Branch_Target)
   );
`else
   logic w_unused;
   assign w_unused = ^{EX_Branch_Valid, EX_Branch_Taken,
                       EX_Branch_PC, EX_Branch_Target};
   assign w_pred       = 1'b0;
   assign w_btb_target = ZERO_VECTOR_32;
`endif

   always_comb begin
      w_pc_next = w_pc_plus4;
      priority case (1'b1)
         EX_Mispredict: w_pc_next = align_pc(EX_Redirect_PC);
         !PC_Write:     w_pc_next = r_pc;
         w_pred:        w_pc_next = align_pc(w_btb_target);
         default:       w_pc_next = w_pc_plus4;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_pc <= align_pc(RESET_PC);
      else        r_pc <= w_pc_next;
   end

   assign Imem_Addr        = r_pc;
   assign IF_PC_New        = w_pc_plus4;
   assign IF_Prediction    = w_pred;
   assign IF_Branch_Target = w_btb_target;
   assign IF_ID_Flush      = EX_Mispredict;

endmodule
